// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, tick/sub-tick bit timing,
// 8 data bits LSB first, optional 9th bit, pending/overflow/framing flags.
module uart_rx (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_en,
  input  logic [15:0] uart_baud,
  input  logic        uart_div_sel,
  input  logic        uart_prty_en,
  input  logic        uart_rxie,
  input  logic        uart_rxd,
  input  logic        uart_rxpnd_clr,
  output logic [7:0]  rxbuf,
  output logic        rx_9bit,
  output logic        uart_rxpnd,
  output logic        rx_frm_err,
  output logic        rx_ovf,
  output logic        rx_busy,
  output logic        uart_rx_int
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    BIT9,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        rxd_s1;
  logic        rxd_s2;
  logic        rxd_s3;
  logic        start_edge;

  logic [15:0] cnt;
  logic [1:0]  sub;
  logic [1:0]  sub_last;
  logic [1:0]  sub_smp;
  logic        tick;
  logic        smp;
  logic        adv;
  logic        cnt_clr;

  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        bit9_r;
  logic        done;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign start_edge = rxd_s3 & ~rxd_s2;

  always_comb begin
    sub_last = uart_div_sel ? 2'd2 : 2'd3;
    sub_smp  = uart_div_sel ? 2'd1 : 2'd2;
    tick     = (cnt == uart_baud);
    smp      = tick & (sub == sub_smp);
    adv      = tick & (sub == sub_last);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!uart_en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_edge) state_nxt = START;
        end
        START: begin
          if (smp && rxd_s2) state_nxt = IDLE;
          else if (adv)      state_nxt = DATA;
        end
        DATA: begin
          if (adv && bit_cnt == 3'd7)
            state_nxt = uart_prty_en ? BIT9 : STOP;
        end
        BIT9: begin
          if (adv) state_nxt = STOP;
        end
        STOP: begin
          // leave mid-bit so a back-to-back start edge is not missed
          if (smp) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy     = (state != IDLE);
    uart_rx_int = uart_rxpnd & uart_rxie;
    done        = uart_en & (state == STOP) & smp;
    cnt_clr     = ~uart_en | (state == IDLE) | (state_nxt == IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= 16'd0;
      sub <= 2'd0;
    end else if (cnt_clr) begin
      cnt <= 16'd0;
      sub <= 2'd0;
    end else if (tick) begin
      cnt <= 16'd0;
      sub <= (sub == sub_last) ? 2'd0 : sub + 2'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      bit9_r  <= 1'b0;
    end else begin
      if (state == START) begin
        bit_cnt <= 3'd0;
        bit9_r  <= 1'b0;
      end
      if (state == DATA && adv)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == DATA && smp)
        shreg <= {rxd_s2, shreg[7:1]};
      if (state == BIT9 && smp)
        bit9_r <= rxd_s2;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxbuf      <= 8'd0;
      rx_9bit    <= 1'b0;
      uart_rxpnd <= 1'b0;
      rx_frm_err <= 1'b0;
      rx_ovf     <= 1'b0;
    end else if (done && (uart_rxpnd_clr || !uart_rxpnd)) begin
      rxbuf      <= shreg;
      rx_9bit    <= uart_prty_en & bit9_r;
      uart_rxpnd <= 1'b1;
      rx_frm_err <= ~rxd_s2;
      if (uart_rxpnd_clr) rx_ovf <= 1'b0;
    end else if (done) begin
      rx_ovf <= 1'b1;
    end else if (uart_rxpnd_clr) begin
      uart_rxpnd <= 1'b0;
      rx_frm_err <= 1'b0;
      rx_ovf     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-built corner sequences,
// and random frames checked against a frame-level flag model.
module tb_uart_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        uart_en = 1'b1;
  logic [15:0] uart_baud = 16'd1;
  logic        uart_div_sel = 1'b0;
  logic        uart_prty_en = 1'b0;
  logic        uart_rxie = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        uart_rxpnd_clr = 1'b0;
  logic [7:0]  rxbuf;
  logic        rx_9bit;
  logic        uart_rxpnd;
  logic        rx_frm_err;
  logic        rx_ovf;
  logic        rx_busy;
  logic        uart_rx_int;

  uart_rx dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .uart_en        (uart_en),
    .uart_baud      (uart_baud),
    .uart_div_sel   (uart_div_sel),
    .uart_prty_en   (uart_prty_en),
    .uart_rxie      (uart_rxie),
    .uart_rxd       (uart_rxd),
    .uart_rxpnd_clr (uart_rxpnd_clr),
    .rxbuf          (rxbuf),
    .rx_9bit        (rx_9bit),
    .uart_rxpnd     (uart_rxpnd),
    .rx_frm_err     (rx_frm_err),
    .rx_ovf         (rx_ovf),
    .rx_busy        (rx_busy),
    .uart_rx_int    (uart_rx_int)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int rise_at;

  logic [7:0] m_buf;
  logic       m_9, m_pnd, m_ferr, m_ovf;

  typedef struct {
    logic [15:0] baud;
    logic        div;
    logic        prty;
    logic [7:0]  data;
    logic        b9;
    logic        stp;
    logic        clr_first;
    logic [7:0]  e_buf;
    logic        e_9;
    logic        e_pnd;
    logic        e_ferr;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_buf = 8'h00; m_9 = 0; m_pnd = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic model_clr();
    m_pnd = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic b9,
                             input logic stp, input logic clr_same);
    if (clr_same || !m_pnd) begin
      m_buf  = d;
      m_9    = uart_prty_en & b9;
      m_pnd  = 1;
      m_ferr = !stp;
      if (clr_same) m_ovf = 0;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".buf"},  32'(rxbuf),       32'(m_buf));
    chk({tag, ".b9"},   32'(rx_9bit),     32'(m_9));
    chk({tag, ".pnd"},  32'(uart_rxpnd),  32'(m_pnd));
    chk({tag, ".ferr"}, 32'(rx_frm_err),  32'(m_ferr));
    chk({tag, ".ovf"},  32'(rx_ovf),      32'(m_ovf));
    chk({tag, ".busy"}, 32'(rx_busy),     32'd0);
    chk({tag, ".int"},  32'(uart_rx_int), 32'(m_pnd & uart_rxie));
  endtask

  task automatic pulse_clr();
    uart_rxpnd_clr = 1;
    @(posedge sys_clk); #1;
    uart_rxpnd_clr = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (rx_busy && k < 100) begin
      @(posedge sys_clk); #1;
      k++;
    end
    if (rx_busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle act=busy exp=idle");
    end
  endtask

  // Cycle index (from the line falling) of the stop-bit sample cycle:
  // 3 cycles of sync/edge latency, then bits of N*(baud+1) clocks each.
  function automatic int stop_idx();
    int t, n, s, nb;
    t  = int'(uart_baud) + 1;
    n  = uart_div_sel ? 3 : 4;
    s  = uart_div_sel ? 1 : 2;
    nb = uart_prty_en ? 10 : 9;
    return 3 + nb * n * t + (s + 1) * t - 1;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic b9,
                            input logic stp, input int clr_at,
                            input int rst_at);
    logic fr [0:10];
    int   p, nb, total;
    logic prev;
    p  = (uart_div_sel ? 3 : 4) * (int'(uart_baud) + 1);
    nb = uart_prty_en ? 11 : 10;
    fr[0] = 1'b0;
    for (int j = 0; j < 8; j++) fr[j+1] = d[j];
    fr[9]  = uart_prty_en ? b9 : stp;
    fr[10] = stp;
    total = nb * p + 4;
    rise_at = -1;
    prev = uart_rxpnd;
    for (int i = 0; i < total; i++) begin
      if (rst_at >= 0 && i >= rst_at) uart_rxd = 1'b1;
      else uart_rxd = (i / p < nb) ? fr[i / p] : 1'b1;
      sys_rst = (i == rst_at);
      uart_rxpnd_clr = (i == clr_at);
      @(posedge sys_clk); #1;
      if (uart_rxpnd && !prev && rise_at < 0) rise_at = i + 1;
      prev = uart_rxpnd;
    end
    sys_rst = 0;
    uart_rxpnd_clr = 0;
    uart_rxd = 1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy_seen;
    vecs[0] = '{16'd1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1,
                8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'd2, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1,
                8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'd1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1,
                8'h55, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1,
                8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'd3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1,
                8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'd1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1,
                8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'd1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0,
                8'h11, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 0;
    @(posedge sys_clk); #1;
    model_reset();
    check_all("reset");

    for (int i = 0; i < 7; i++) begin
      uart_baud    = vecs[i].baud;
      uart_div_sel = vecs[i].div;
      uart_prty_en = vecs[i].prty;
      if (vecs[i].clr_first) begin
        pulse_clr();
        model_clr();
      end
      send_frame(vecs[i].data, vecs[i].b9, vecs[i].stp, -1, -1);
      wait_idle();
      model_frame(vecs[i].data, vecs[i].b9, vecs[i].stp, 1'b0);
      if (i == 0) begin
        checks++;
        if (rise_at < 77 || rise_at > 81) begin
          failures++;
          $display("FAIL vec0.latency act=%0d exp=77..81", rise_at);
        end
      end
      chk($sformatf("vec%0d.buf", i),  32'(rxbuf),      32'(vecs[i].e_buf));
      chk($sformatf("vec%0d.b9", i),   32'(rx_9bit),    32'(vecs[i].e_9));
      chk($sformatf("vec%0d.pnd", i),  32'(uart_rxpnd), 32'(vecs[i].e_pnd));
      chk($sformatf("vec%0d.ferr", i), 32'(rx_frm_err), 32'(vecs[i].e_ferr));
      chk($sformatf("vec%0d.ovf", i),  32'(rx_ovf),     32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d.int", i),  32'(uart_rx_int), 32'(vecs[i].e_pnd));
    end

    // clear lands exactly on the stop sample of the second frame
    send_frame(8'h22, 1'b0, 1'b1, stop_idx(), -1);
    wait_idle();
    model_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check_all("coinc_clr");

    pulse_clr();
    model_clr();
    check_all("clr_only");

    // short low glitch must be rejected as a false start
    uart_baud = 16'd3;
    uart_div_sel = 1'b0;
    busy_seen = 0;
    uart_rxd = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) uart_rxd = 1;
      @(posedge sys_clk); #1;
      if (rx_busy) busy_seen = 1;
    end
    wait_idle();
    chk("glitch.busy_seen", 32'(busy_seen), 32'd1);
    check_all("glitch");

    // reset in the middle of DATA bit 4, then a clean frame
    uart_baud = 16'd1;
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
    wait_idle();
    model_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_all("pre_rst");
    send_frame(8'hF0, 1'b0, 1'b1, -1, 3 + 5 * 8 + 3);
    model_reset();
    check_all("mid_rst");
    send_frame(8'h81, 1'b0, 1'b1, -1, -1);
    wait_idle();
    model_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check_all("after_rst");

    for (int r = 0; r < 24; r++) begin
      logic [7:0] d;
      logic b9, stp;
      uart_baud    = 16'($urandom_range(0, 3));
      uart_div_sel = 1'($urandom_range(0, 1));
      uart_prty_en = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      b9  = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        pulse_clr();
        model_clr();
      end
      send_frame(d, b9, stp, -1, -1);
      wait_idle();
      model_frame(d, b9, stp, 1'b0);
      check_all($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have exactly one clock, sys_clk, and an asynchronous active-high reset, sys_rst; every flop SHALL reset asynchronously on sys_rst=1.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- sys_clk  in  1  system clock
- sys_rst  in  1  async reset, active high
- uart_en  in  1  receiver enable
- uart_baud  in  16  sample-tick period minus 1
- uart_div_sel  in  1  0: 4 ticks/bit; 1: 3 ticks/bit
- uart_prty_en  in  1  frame carries 9th bit
- uart_rxie  in  1  RX interrupt enable
- uart_rxd  in  1  async serial line, idle high
- uart_rxpnd_clr  in  1  clears pending and error flags
- rxbuf  out  8  last received data byte
- rx_9bit  out  1  last received 9th bit; 0 when uart_prty_en=0
- uart_rxpnd  out  1  byte available
- rx_frm_err  out  1  stop bit sampled low
- rx_ovf  out  1  frame lost while pending
- rx_busy  out  1  state != IDLE
- uart_rx_int  out  1  uart_rxpnd & uart_rxie

Function
REQ-003 uart_rxd SHALL pass 2 sync flops (rxd_s1, rxd_s2) plus a delay flop rxd_s3; the start edge SHALL be rxd_s3 & ~rxd_s2.
REQ-004 Tick counter, 16-bit: tick SHALL assert in the cycle cnt == uart_baud; cnt SHALL return to 0 the next cycle; the tick period SHALL be uart_baud+1 clocks; uart_baud=0 SHALL give a tick every cycle.
REQ-005 Sub counter, 2-bit: N = 3 (div_sel=1) or 4 (div_sel=0); it SHALL increment on tick and wrap to 0 at N-1; the bit period SHALL be N*(uart_baud+1) clocks.
REQ-006 Sample point SHALL be a tick with sub == 1 (N=3) or sub == 2 (N=4); bit advance SHALL be a tick with sub == N-1.
REQ-007 States SHALL be IDLE, START, DATA, BIT9, STOP.
REQ-008 IDLE: tick and sub counters SHALL be held at 0; on a start edge with uart_en=1 the block SHALL go to START.
REQ-009 START, at the sample point: rxd_s2=1 SHALL be treated as a false start and return the block to IDLE with no flags changed; rxd_s2=0 SHALL keep the block in START until bit advance, then go to DATA.
REQ-010 DATA SHALL shift rxd_s2 into the shift register at each sample point, LSB first; after the 8th bit advance it SHALL go to BIT9 if uart_prty_en=1, else to STOP.
REQ-011 BIT9 SHALL capture rxd_s2 at the sample point and go to STOP on bit advance; the bit SHALL be captured as received, not parity-checked.
REQ-012 STOP SHALL sample at the sample point and then go to IDLE in the same cycle, without waiting for the bit end, so a back-to-back start is accepted.
REQ-013 Completion (STOP sample cycle) with uart_rxpnd=0: on the next clock rxbuf and rx_9bit SHALL load, uart_rxpnd SHALL be 1, and rx_frm_err SHALL be set if the stop sample = 0.
REQ-014 Completion with uart_rxpnd=1 and no clear: rxbuf and rx_9bit SHALL hold, rx_ovf SHALL set, and no frm_err update SHALL occur.
REQ-015 Completion in the same cycle as uart_rxpnd_clr: the block SHALL load per REQ-013, uart_rxpnd SHALL stay 1, rx_ovf SHALL not set, and the prior error flags SHALL clear before the new frm_err is applied.
REQ-016 uart_rxpnd_clr without completion SHALL clear uart_rxpnd, rx_ovf and rx_frm_err on the next clock; rxbuf SHALL hold.
REQ-017 uart_en=0 SHALL force IDLE and zero both counters within 1 clock; flags and rxbuf SHALL hold; a partial frame SHALL be discarded.
REQ-018 uart_baud and uart_div_sel changes mid-frame SHALL take effect at the next tick compare; no protection SHALL be provided.

Reset
REQ-019 On sys_rst: state IDLE, counters 0, rxd_s1/s2/s3 = 1, shift register 0, rxbuf=0x00, rx_9bit=0, uart_rxpnd=0, rx_frm_err=0, rx_ovf=0, rx_busy=0, uart_rx_int=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL NOT detect a start until rxd_s3 has seen 1 followed by 0.

Verification
REQ-021 Setup uart_baud=1, div_sel=0 (8 clocks/bit), prty_en=0; send 0xA5 with stop=1 -> rxbuf=0xA5, uart_rxpnd=1, rx_frm_err=0, with uart_rxpnd rising 3+9.5x8 clocks (+/-2) after the line falls.
REQ-022 prty_en=1, div_sel=1, uart_baud=2 (9 clocks/bit); send 0x3C with 9th bit=1 -> rxbuf=0x3C, rx_9bit=1; with uart_rxie=1, uart_rx_int=1.
REQ-023 Low glitch of 3 clocks at uart_baud=3 -> rx_busy pulses then returns to 0; uart_rxpnd stays 0; rxbuf unchanged.
REQ-024 Frame 0x55 with stop=0 -> rx_frm_err=1, rxbuf=0x55; a uart_rxpnd_clr pulse -> rx_frm_err=0, uart_rxpnd=0.
REQ-025 Two frames 0x11 then 0x22, no clear -> rxbuf=0x11, rx_ovf=1; clear coincident with the STOP sample of 0x22 -> rxbuf=0x22, rx_ovf=0.
REQ-026 sys_rst pulse at DATA bit 4 -> all outputs at reset values; the next full frame 0x81 is received correctly.
